// File: rtl/char_ram_arbiter_pkg.sv
// rtl/char_ram_arbiter_pkg.sv - shared constants and state type for the character RAM arbiter
package char_ram_arbiter_pkg;

    localparam int          DEF_RAM_BITS   = 13;
    localparam int          DEF_NUM_COLS   = 80;
    localparam int          DEF_NUM_ROWS   = 80;
    localparam int          DEF_FIFO_DEPTH = 4;
    localparam logic [7:0]  DEF_FILL_CHAR  = 8'h20;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } arb_state_t;

    function automatic int level_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/char_ram_arbiter_if.sv
// rtl/char_ram_arbiter_if.sv - UART write, video read, clear control and RAM port bundle
interface char_ram_arbiter_if
    import char_ram_arbiter_pkg::*;
#(
    parameter int RAM_BITS   = DEF_RAM_BITS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
    localparam int LVL_W = level_bits(FIFO_DEPTH);

    logic [RAM_BITS-1:0] wr_addr;
    logic [7:0]          wr_data;
    logic                wr_stb;
    logic                vid_req;
    logic [RAM_BITS-1:0] vid_addr;
    logic                vid_valid;
    logic [7:0]          vid_rdata;
    logic                clr_req;
    logic                clr_busy;
    logic                clr_done;
    logic                wr_overflow;
    logic [LVL_W-1:0]    fifo_level;
    logic                mem_en;
    logic                mem_we;
    logic [RAM_BITS-1:0] mem_addr;
    logic [7:0]          mem_wdata;
    logic [7:0]          mem_rdata;

    modport master (
        output wr_addr, wr_data, wr_stb, vid_req, vid_addr, clr_req, mem_rdata,
        input  vid_valid, vid_rdata, clr_busy, clr_done, wr_overflow, fifo_level,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  wr_addr, wr_data, wr_stb, vid_req, vid_addr, clr_req, mem_rdata,
        output vid_valid, vid_rdata, clr_busy, clr_done, wr_overflow, fifo_level,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/char_wr_fifo.sv
// rtl/char_wr_fifo.sv - synchronous write-buffer FIFO; a push into a full FIFO succeeds only alongside a pop
module char_wr_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/char_ram_arbiter.sv
// rtl/char_ram_arbiter.sv - single-port character RAM arbiter: video reads, clear sweep, buffered UART writes
module char_ram_arbiter
    import char_ram_arbiter_pkg::*;
#(
    parameter int         RAM_BITS   = DEF_RAM_BITS,
    parameter int         NUM_COLS   = DEF_NUM_COLS,
    parameter int         NUM_ROWS   = DEF_NUM_ROWS,
    parameter int         FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [7:0] FILL_CHAR  = DEF_FILL_CHAR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    char_ram_arbiter_if.slave     bus
);
    localparam int                  LVL_W     = level_bits(FIFO_DEPTH);
    localparam logic [RAM_BITS-1:0] LAST_ADDR = RAM_BITS'(NUM_COLS * NUM_ROWS - 1);

    arb_state_t            state;
    logic [RAM_BITS-1:0]   clr_ptr;
    logic                  grant_clr;
    logic                  grant_fifo;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LVL_W-1:0]      level;
    logic [RAM_BITS+7:0]   head;

    char_wr_fifo #(
        .WIDTH (RAM_BITS + 8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.wr_stb),
        .din   ({bus.wr_addr, bus.wr_data}),
        .pop   (grant_fifo),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Video always wins; the buffered writes wait out the whole clear sweep.
    assign grant_clr  = !bus.vid_req && (state == S_CLEAR);
    assign grant_fifo = !bus.vid_req && (state != S_CLEAR) && !fifo_empty;

    assign bus.mem_en     = rst_n && (bus.vid_req || grant_clr || grant_fifo);
    assign bus.mem_we     = rst_n && (grant_clr || grant_fifo);
    assign bus.vid_rdata  = bus.mem_rdata;
    assign bus.fifo_level = level;

    always_comb begin
        bus.mem_addr  = head[RAM_BITS+7:8];
        bus.mem_wdata = head[7:0];
        if (bus.vid_req) begin
            bus.mem_addr = bus.vid_addr;
        end else if (grant_clr) begin
            bus.mem_addr  = clr_ptr;
            bus.mem_wdata = FILL_CHAR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            clr_ptr         <= '0;
            bus.vid_valid   <= 1'b0;
            bus.clr_busy    <= 1'b0;
            bus.clr_done    <= 1'b0;
            bus.wr_overflow <= 1'b0;
        end else begin
            bus.vid_valid <= bus.vid_req;
            bus.clr_done  <= 1'b0;
            if (bus.wr_stb && fifo_full && !grant_fifo) bus.wr_overflow <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (bus.clr_req) begin
                        state        <= S_CLEAR;
                        clr_ptr      <= '0;
                        bus.clr_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (grant_clr) begin
                        if (clr_ptr == LAST_ADDR) begin
                            state        <= S_IDLE;
                            clr_ptr      <= '0;
                            bus.clr_busy <= 1'b0;
                            bus.clr_done <= 1'b1;
                        end else begin
                            clr_ptr <= clr_ptr + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_ram_arbiter.sv
// tb/tb_char_ram_arbiter.sv - scoreboard bench for char_ram_arbiter against a queue-based reference model
module tb_char_ram_arbiter;

    localparam int RB    = 13;
    localparam int DEPTH = 4;
    localparam int LAST  = 80 * 80 - 1;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       ovf;
        logic       vv;
        logic [2:0] level;
    } stat_t;

    typedef struct packed {
        logic [RB-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;

    char_ram_arbiter_if #(.RAM_BITS(RB), .FIFO_DEPTH(DEPTH)) bus ();

    char_ram_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram       [1 << RB];
    logic [7:0] model_ram [1 << RB];

    stat_t         stat_q[$];
    wr_t           wr_q[$];
    logic [RB-1:0] rd_addr_q[$];
    logic [7:0]    rd_data_q[$];

    // Reference model state
    wr_t m_fifo[$];
    bit  m_clr;
    int  m_ptr;
    bit  m_done;
    bit  m_ovf;
    bit  m_vv;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic step(input bit vr, input logic [RB-1:0] va, input bit ws,
                        input logic [RB-1:0] wa, input logic [7:0] wd, input bit cr);
        stat_t s;
        wr_t   w;
        bit    was_clr;
        @(posedge clk);
        #1;
        bus.vid_req  = vr;
        bus.vid_addr = va;
        bus.wr_stb   = ws;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.clr_req  = cr;
        s.busy  = m_clr;
        s.done  = m_done;
        s.ovf   = m_ovf;
        s.vv    = m_vv;
        s.level = 3'(m_fifo.size());
        stat_q.push_back(s);
        was_clr = m_clr;
        m_done  = 1'b0;
        if (vr) begin
            rd_addr_q.push_back(va);
            rd_data_q.push_back(model_ram[va]);
        end else if (m_clr) begin
            w.addr = RB'(m_ptr);
            w.data = 8'h20;
            wr_q.push_back(w);
            model_ram[m_ptr] = 8'h20;
            if (m_ptr == LAST) begin
                m_clr  = 1'b0;
                m_done = 1'b1;
            end else begin
                m_ptr++;
            end
        end else if (m_fifo.size() > 0) begin
            w = m_fifo.pop_front();
            wr_q.push_back(w);
            model_ram[w.addr] = w.data;
        end
        if (ws) begin
            if (m_fifo.size() < DEPTH) begin
                w.addr = wa;
                w.data = wd;
                m_fifo.push_back(w);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (cr && !was_clr) begin
            m_clr = 1'b1;
            m_ptr = 0;
        end
        m_vv = vr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n        = 1'b0;
        bus.vid_req  = 1'b1;
        bus.vid_addr = RB'(7);
        bus.wr_stb   = 1'b1;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.clr_req  = 1'b0;
        #1;
        chk("reset_outputs",
            32'({bus.vid_valid, bus.clr_busy, bus.clr_done, bus.wr_overflow,
                 bus.fifo_level, bus.mem_en, bus.mem_we}), 32'd0);
        m_fifo.delete();
        stat_q.delete();
        wr_q.delete();
        rd_addr_q.delete();
        rd_data_q.delete();
        m_clr  = 1'b0;
        m_ptr  = 0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
        m_vv   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        bus.vid_req = 1'b0;
        bus.wr_stb  = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        stat_t s;
        wr_t   w;
        int    mism;
        int    guard;
        rst_n        = 1'b0;
        bus.vid_req  = 1'b0;
        bus.vid_addr = '0;
        bus.wr_stb   = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.clr_req  = 1'b0;
        for (int i = 0; i < (1 << RB); i++) begin
            ram[i]       <= 8'(i * 7 + 3);
            model_ram[i] = 8'(i * 7 + 3);
        end

        fork
            forever begin
                @(posedge clk);
                if (bus.mem_en) begin
                    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
                    else            bus.mem_rdata     <= ram[bus.mem_addr];
                end
            end
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (stat_q.size() > 0) begin
                        s = stat_q.pop_front();
                        chk("status", 32'({bus.clr_busy, bus.clr_done, bus.wr_overflow,
                                           bus.vid_valid, bus.fifo_level}), 32'(s));
                    end
                    if (bus.mem_en && bus.mem_we) begin
                        if (wr_q.size() == 0) begin
                            chk("unexpected_write", 32'({bus.mem_addr, bus.mem_wdata}), 32'hFFFF_FFFF);
                        end else begin
                            w = wr_q.pop_front();
                            chk("write", 32'({bus.mem_addr, bus.mem_wdata}), 32'(w));
                        end
                    end
                    if (bus.mem_en && !bus.mem_we) begin
                        if (rd_addr_q.size() == 0)
                            chk("unexpected_read", 32'(bus.mem_addr), 32'hFFFF_FFFF);
                        else
                            chk("read_addr", 32'(bus.mem_addr), 32'(rd_addr_q.pop_front()));
                    end
                    if (bus.vid_valid) begin
                        if (rd_data_q.size() == 0)
                            chk("unexpected_vid_valid", 32'(bus.vid_rdata), 32'hFFFF_FFFF);
                        else
                            chk("vid_rdata", 32'(bus.vid_rdata), 32'(rd_data_q.pop_front()));
                    end
                end
            end
        join_none

        #2;
        chk("reset_state", 32'({bus.vid_valid, bus.clr_busy, bus.clr_done, bus.wr_overflow,
                                bus.fifo_level, bus.mem_en, bus.mem_we}), 32'd0);
        m_fifo.delete();
        m_clr = 0; m_ptr = 0; m_done = 0; m_ovf = 0; m_vv = 0;
        #10;
        rst_n = 1'b1;

        // Single buffered write
        step(0, '0, 1, RB'(5), 8'h41, 0);
        idle(3);

        // Video held four cycles while three writes queue up
        step(1, RB'(100), 1, RB'(10), 8'hA1, 0);
        step(1, RB'(101), 1, RB'(11), 8'hA2, 0);
        step(1, RB'(102), 1, RB'(12), 8'hA3, 0);
        step(1, RB'(103), 0, '0, '0, 0);
        idle(5);

        // Overflow: five writes into a four-deep buffer under continuous video
        for (int i = 0; i < 5; i++) step(1, RB'(200 + i), 1, RB'(20 + i), 8'(8'hB0 + i), 0);
        step(1, RB'(300), 0, '0, '0, 0);
        idle(8);

        // Full clear sweep with no competing traffic
        step(0, '0, 0, '0, '0, 1);
        idle(LAST + 4);

        // Write to address 0 landing mid-sweep must survive the clear
        step(0, '0, 0, '0, '0, 1);
        for (int i = 0; i < 9; i++) step(0, '0, 0, '0, '0, 0);
        step(0, '0, 1, '0, 8'h58, 0);
        guard = 0;
        while (m_clr && guard < 8000) begin
            step(0, '0, 0, '0, '0, 0);
            guard++;
        end
        idle(4);
        #2;
        chk("ram0_after_clear", 32'(ram[0]), 32'h58);

        // Reset mid-sweep aborts without clr_done, then the sweep restarts at 0
        step(0, '0, 0, '0, '0, 1);
        guard = 0;
        while (m_ptr != 100 && guard < 300) begin
            step(0, '0, 0, '0, '0, 0);
            guard++;
        end
        chk("sweep_reached_100", 32'(m_ptr), 32'd100);
        apply_reset();
        idle(3);
        step(0, '0, 0, '0, '0, 1);
        idle(20);

        // Randomised traffic, including clears racing video and UART writes
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 9) < 4, RB'($urandom), $urandom_range(0, 9) < 3,
                 RB'($urandom), 8'($urandom), $urandom_range(0, 999) < 2);
        end
        guard = 0;
        while ((m_clr || m_fifo.size() > 0) && guard < 20000) begin
            step($urandom_range(0, 9) < 3, RB'($urandom), 0, '0, '0, 0);
            guard++;
        end
        chk("drain_timeout", 32'(m_clr || m_fifo.size() > 0), 32'd0);
        idle(3);
        @(negedge clk);
        #1;
        chk("queues_empty", 32'(wr_q.size() + rd_addr_q.size() + rd_data_q.size() + stat_q.size()), 32'd0);
        mism = 0;
        for (int i = 0; i < (1 << RB); i++) if (ram[i] !== model_ram[i]) mism++;
        chk("ram_contents", 32'(mism), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
